ram_fifo_sync: RTL

RAM_FIFO_SYNC -- requirements
Module: ram_fifo_sync

---
 rtl/ram_fifo_sync.sv | 115 +++++++++++
 1 files changed

// File: rtl/ram_fifo_sync.sv
// Synchronous single-clock FIFO built on an unreset storage array with a registered read port.
// Occupancy comes from wrapping pointers, and overflow/underflow are sticky error flags.
module ram_fifo_sync #(
  parameter int DW    = 32,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH),
  parameter int AFULL = DEPTH - 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_din,
  input  logic          rd_en,
  output logic [DW-1:0] rd_dout,
  output logic          rd_valid,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic          underflow,
  input  logic          err_clr
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_C = (AW+1)'(AFULL);

  logic [DW-1:0] mem_q [DEPTH];

  logic [AW:0]   wr_ptr_q,    wr_ptr_d;
  logic [AW:0]   rd_ptr_q,    rd_ptr_d;
  logic [DW-1:0] rd_dout_q,   rd_dout_d;
  logic          rd_valid_q,  rd_valid_d;
  logic          overflow_q,  overflow_d;
  logic          underflow_q, underflow_d;

  logic wr_accept;
  logic rd_accept;

  // The extra pointer MSB separates full from empty, so the difference is the occupancy.
  assign count       = wr_ptr_q - rd_ptr_q;
  assign full        = (count == DEPTH_C);
  assign empty       = (count == '0);
  assign almost_full = (count >= AFULL_C);

  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  // NOTE: every always_comb output is given its default first; a path that
  // leaves one unassigned would otherwise infer a latch.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rd_dout_d   = rd_dout_q;
    rd_valid_d  = rd_accept;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end

    if (rd_accept) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_dout_d = mem_q[rd_ptr_q[AW-1:0]];
    end

    // A new error event wins over a clear issued on the same edge.
    if (wr_en && full) begin
      overflow_d = 1'b1;
    end else if (err_clr) begin
      overflow_d = 1'b0;
    end

    if (rd_en && empty) begin
      underflow_d = 1'b1;
    end else if (err_clr) begin
      underflow_d = 1'b0;
    end
  end

  // NOTE: storage is deliberately left out of reset; the reset pointers already
  // mark every entry invalid, and an unreset array can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_din;
    end
  end

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      rd_dout_q   <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      rd_dout_q   <= rd_dout_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign rd_dout   = rd_dout_q;
  assign rd_valid  = rd_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule
